// File: rtl/spi_master.sv
// SPI bus master: AXI-Stream words are queued in a TX FIFO, shifted out MSB-first one cs frame
// per word, and received words return through an RX FIFO. Build option: SPI_MASTER_LOOPBACK_EN.
module spi_master #(
    parameter int unsigned TRANSFER_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter bit          CPOL           = 1'b0,
    parameter bit          CPHA           = 1'b0,
    parameter int unsigned CLK_DIV        = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      miso,
    output logic                      cs,
    output logic                      sck,
    output logic                      mosi,
    input  logic [TRANSFER_WIDTH-1:0] mosi_tdata,
    input  logic                      mosi_tvalid,
    output logic                      mosi_tready,
    input  logic                      mosi_tlast,
    input  logic                      mosi_tkeep,
    output logic [TRANSFER_WIDTH-1:0] miso_tdata,
    output logic                      miso_tvalid,
    input  logic                      miso_tready,
    output logic                      miso_tlast,
    output logic                      miso_tkeep
);
    localparam int unsigned W  = TRANSFER_WIDTH;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HW = $clog2(2 * W);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] half_q, half_d;
    logic [W-1:0]  tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic          cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;
    logic          en_q;

    logic [W-1:0]  tx_mem [FIFO_DEPTH];
    logic [W-1:0]  rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [CW-1:0] tx_cnt_q, rx_cnt_q;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          half_end, last_half, shift_edge, sample_en, sample_bit;
    logic          unused_inputs;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_bit = mosi_q;
`else
    assign sample_bit = miso;
`endif
    assign unused_inputs = ^{mosi_tlast, mosi_tkeep, miso};

    assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_push  = mosi_tvalid & mosi_tready;
    assign rx_pop   = miso_tvalid & miso_tready;
    assign rx_push  = (state_q == StHold) && (div_q == '0);

    assign mosi_tready = en_q & ~tx_full;
    assign miso_tvalid = ~rx_empty;
    assign miso_tdata  = rx_mem[rx_rd_q];
    assign miso_tlast  = 1'b1;
    assign miso_tkeep  = 1'b1;
    assign cs   = cs_q;
    assign sck  = sck_q;
    assign mosi = mosi_q;

    assign half_end   = (div_q == DW'(CLK_DIV - 1));
    assign last_half  = (half_q == HW'(2 * W - 1));
    // Even half-periods start with the leading SCK edge, odd ones with the trailing edge.
    assign shift_edge = CPHA ? half_q[0] : ~half_q[0];
    assign sample_en  = (state_q == StShift) && (div_q == '0) && (half_q[0] == CPHA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            en_q     <= 1'b1;
            tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
            rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= mosi_tdata;
        if (rx_push) rx_mem[rx_wr_q] <= rx_sr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            half_q  <= '0;
            tx_sr_q <= '0;
            rx_sr_q <= '0;
            cs_q    <= 1'b1;
            sck_q   <= CPOL;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            tx_sr_q <= tx_sr_d;
            rx_sr_q <= rx_sr_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;
        tx_pop  = 1'b0;
        div_d   = half_end ? '0 : div_q + 1'b1;
        if (sample_en) rx_sr_d = {rx_sr_q[W-2:0], sample_bit};
        unique case (state_q)
            StIdle: begin
                // Saturate so the cs-high gap is never shorter than one half-period.
                if (half_end) begin
                    div_d = div_q;
                    if (!tx_empty && !rx_full) begin
                        tx_pop  = 1'b1;
                        tx_sr_d = tx_mem[tx_rd_q];
                        div_d   = '0;
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                if (half_end) begin
                    half_d  = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (half_end) begin
                    half_d = half_q + 1'b1;
                    if (shift_edge) tx_sr_d = tx_sr_q << 1;
                    if (last_half) state_d = StHold;
                end
            end
            StHold: begin
                if (half_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cs_d   = 1'b1;
        sck_d  = CPOL;
        mosi_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cs_d = 1'b1;
            end
            StSetup: begin
                cs_d   = 1'b0;
                mosi_d = CPHA ? 1'b0 : tx_sr_q[W-1];
            end
            StShift: begin
                cs_d   = 1'b0;
                sck_d  = CPOL ^ ~half_q[0];
                mosi_d = tx_sr_q[W-1];
            end
            StHold: begin
                cs_d = 1'b0;
            end
            default: cs_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: mode 0 (CLK_DIV=2) with switchable external loopback, and mode 3
// (CLK_DIV=1) with miso tied to mosi.
module tb_spi_master;
`ifdef SPI_MASTER_LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       miso, cs, sck, mosi, tvalid, tready, rvalid, rready, rlast, rkeep;
    logic [7:0] tdata, rdata;
    logic       force_en, force_val;
    assign miso = force_en ? force_val : mosi;

    logic       miso3, cs3, sck3, mosi3, tvalid3, tready3, rvalid3, rready3, rlast3, rkeep3;
    logic [7:0] tdata3, rdata3;
    assign miso3 = mosi3;

    spi_master #(
        .TRANSFER_WIDTH(8), .FIFO_DEPTH(2), .CPOL(1'b0), .CPHA(1'b0), .CLK_DIV(2)
    ) dut (
        .clk(clk), .reset(rst_n), .miso(miso), .cs(cs), .sck(sck), .mosi(mosi),
        .mosi_tdata(tdata), .mosi_tvalid(tvalid), .mosi_tready(tready),
        .mosi_tlast(1'b1), .mosi_tkeep(1'b1),
        .miso_tdata(rdata), .miso_tvalid(rvalid), .miso_tready(rready),
        .miso_tlast(rlast), .miso_tkeep(rkeep)
    );

    spi_master #(
        .TRANSFER_WIDTH(8), .FIFO_DEPTH(2), .CPOL(1'b1), .CPHA(1'b1), .CLK_DIV(1)
    ) dut3 (
        .clk(clk), .reset(rst_n), .miso(miso3), .cs(cs3), .sck(sck3), .mosi(mosi3),
        .mosi_tdata(tdata3), .mosi_tvalid(tvalid3), .mosi_tready(tready3),
        .mosi_tlast(1'b0), .mosi_tkeep(1'b0),
        .miso_tdata(rdata3), .miso_tvalid(rvalid3), .miso_tready(rready3),
        .miso_tlast(rlast3), .miso_tkeep(rkeep3)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin monitors, sampled 2 time units after each rising clk edge.
    int         pulses = 0, low_cnt = 0, last_low = 0, gap = 0, last_gap = 0;
    int         frames = 0, fall_cyc = 0;
    logic [7:0] mosi_sr = '0;
    logic       cs_p = 1'b1, sck_p = 1'b0, sck_at_rise = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (cs_p && !cs) begin
            fall_cyc = cyc;
            pulses   = 0;
            low_cnt  = 0;
            last_gap = gap;
            frames++;
        end
        if (!cs) begin
            low_cnt++;
            if (sck && !sck_p) begin
                pulses++;
                mosi_sr = {mosi_sr[6:0], mosi};
            end
        end
        if (!cs_p && cs) begin
            last_low    = low_cnt;
            sck_at_rise = sck;
        end
        gap   = cs ? gap + 1 : 0;
        cs_p  = cs;
        sck_p = sck;
    end

    int         pulses3 = 0, bad3 = 0;
    logic [7:0] mosi3_sr = '0;
    logic       cs3_p = 1'b1, sck3_p = 1'b1, mosi3_p = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (cs3_p && !cs3) pulses3 = 0;
        if (!cs3 && sck3 && !sck3_p) begin
            pulses3++;
            mosi3_sr = {mosi3_sr[6:0], mosi3};
            if (mosi3 != mosi3_p) bad3++;
        end
        cs3_p   = cs3;
        sck3_p  = sck3;
        mosi3_p = mosi3;
    end

    typedef struct {
        logic [7:0] tx;
        logic       loop;
        logic       miso_val;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
    } vec_t;
    vec_t rows [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        tdata  = d;
        tvalid = 1'b1;
        while (!tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!tready) begin
            check("push_timeout", 0, 1);
            @(negedge clk);
            tvalid = 1'b0;
        end else begin
            @(posedge clk);
            #1 acc = cyc;
            @(negedge clk);
            tvalid = 1'b0;
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        int n = 0;
        while (!rvalid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            check(name, rdata, exp);
            check({name, "_tlast"}, rlast, 1);
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
    endtask

    task automatic wait_cs(input logic lvl);
        int n = 0;
        while (cs !== lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (cs !== lvl) check("cs_wait_timeout", cs, lvl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int f0;
        int n;
        tvalid = 1'b0; tdata = '0; rready = 1'b0; force_en = 1'b0; force_val = 1'b0;
        tvalid3 = 1'b0; tdata3 = '0; rready3 = 1'b0;
        rows = '{
            '{8'h45, 1'b1, 1'b0, 8'h45, 8'h45},
            '{8'hA5, 1'b1, 1'b0, 8'hA5, 8'hA5},
            '{8'h3C, 1'b1, 1'b0, 8'h3C, 8'h3C},
            '{8'h00, 1'b1, 1'b0, 8'h00, 8'h00},
            '{8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF},
            '{8'h96, 1'b0, 1'b0, LB ? 8'h96 : 8'h00, 8'h96},
            '{8'h69, 1'b0, 1'b1, LB ? 8'h69 : 8'hFF, 8'h69}
        };

        repeat (3) @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_tready", tready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_sck_mode3", sck3, 1);
        rst_n = 1'b1;
        #1 check("tready_before_edge", tready, 0);
        @(negedge clk);
        check("tready_after_edge", tready, 1);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            force_en  = !rows[i].loop;
            force_val = rows[i].miso_val;
            push(rows[i].tx);
            wait_cs(1'b0);
            check($sformatf("latency[%0d]", i), fall_cyc - acc, 2);
            pop_check($sformatf("rx[%0d]", i), rows[i].exp_rx);
            wait_cs(1'b1);
            check($sformatf("pulses[%0d]", i), pulses, 8);
            check($sformatf("mosi_bits[%0d]", i), mosi_sr, rows[i].exp_mosi);
            check($sformatf("cs_low_cycles[%0d]", i), last_low, 36);
            check($sformatf("sck_end[%0d]", i), sck_at_rise, 0);
            check($sformatf("mosi_idle[%0d]", i), mosi, 0);
            repeat (4) @(negedge clk);
        end

        // Back-to-back words: two separate frames with a cs-high gap, returned in order.
        force_en = 1'b0;
        f0 = frames;
        push(8'hA5);
        push(8'h3C);
        pop_check("b2b_first", 8'hA5);
        pop_check("b2b_second", 8'h3C);
        wait_cs(1'b1);
        check("b2b_frames", frames - f0, 2);
        check("b2b_gap_ge_div", last_gap >= 2, 1);
        repeat (4) @(negedge clk);

        // RX back-pressure: with the RX FIFO full no further frame may start.
        f0 = frames;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("bp_tx_full_tready", tready, 0);
        push(8'h44);
        repeat (120) @(negedge clk);
        check("bp_frames_stalled", frames - f0, 2);
        check("bp_tready_full", tready, 0);
        check("bp_rvalid", rvalid, 1);
        check("bp_cs_idle", cs, 1);
        pop_check("bp_w1", 8'h11);
        pop_check("bp_w2", 8'h22);
        pop_check("bp_w3", 8'h33);
        pop_check("bp_w4", 8'h44);
        wait_cs(1'b1);
        repeat (4) @(negedge clk);
        check("bp_frames_total", frames - f0, 4);

        // Reset in the middle of SHIFT.
        push(8'hC3);
        wait_cs(1'b0);
        n = 0;
        while (pulses < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_pulses_reached", pulses >= 3, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cs", cs, 1);
        check("midrst_sck", sck, 0);
        check("midrst_rvalid", rvalid, 0);
        check("midrst_tready", tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        push(8'h5A);
        pop_check("post_rst_rx", 8'h5A);
        wait_cs(1'b1);
        check("post_rst_pulses", pulses, 8);
        check("post_rst_mosi", mosi_sr, 8'h5A);
        repeat (4) @(negedge clk);

        // Mode 3: idles high, data launched on falling edges, sampled on rising edges.
        check("m3_idle_sck", sck3, 1);
        check("m3_tready", tready3, 1);
        tdata3  = 8'h81;
        tvalid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tvalid3 = 1'b0;
        n = 0;
        while (!rvalid3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("m3_rvalid", rvalid3, 1);
        check("m3_rx", rdata3, 8'h81);
        check("m3_tlast_tkeep", {rlast3, rkeep3}, 2'b11);
        rready3 = 1'b1;
        @(negedge clk);
        rready3 = 1'b0;
        n = 0;
        while (!cs3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("m3_pulses", pulses3, 8);
        check("m3_mosi_bits", mosi3_sr, 8'h81);
        check("m3_mosi_stable_on_rise", bad3, 0);
        check("m3_sck_end", sck3, 1);
        check("m3_rvalid_drained", rvalid3, 0);

`ifdef SPI_MASTER_LOOPBACK_EN
        force_en  = 1'b1;
        force_val = 1'b0;
        push(8'hF0);
        pop_check("internal_loopback", 8'hF0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
